// File: rtl/axis_to_cmlk_tx_if.sv
// AXI4-Stream video beat bundle (64-bit, 8 px/beat) feeding the CameraLink transmitter.
interface axis_to_cmlk_tx_if;
  logic [63:0] tdata;
  logic        tuser;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_to_cmlk_tx.sv
// CameraLink Full (8-tap x 8-bit) transmitter: AXI4-Stream video in, X/Y/Z channel words out,
// with generated FVAL/LVAL/DVAL frame timing.
module axis_to_cmlk_tx #(
  parameter int unsigned BEATS_PER_LINE  = 256,
  parameter int unsigned LINES_PER_FRAME = 1024,
  parameter int unsigned FV_SETUP        = 4,
  parameter int unsigned H_BLANK         = 16,
  parameter int unsigned FV_HOLD         = 4,
  parameter int unsigned V_BLANK         = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  axis_to_cmlk_tx_if.slave   s_axis,
  output logic [27:0]        cmlk_data_x,
  output logic [27:0]        cmlk_data_y,
  output logic [27:0]        cmlk_data_z,
  input  logic               err_clr,
  output logic               fstart_err,
  output logic               lval_err,
  output logic               underrun
);

  localparam int unsigned BW    = $clog2(BEATS_PER_LINE + 1);
  localparam int unsigned LW    = $clog2(LINES_PER_FRAME + 1);
  localparam int unsigned MAX_A = (FV_SETUP > H_BLANK) ? FV_SETUP : H_BLANK;
  localparam int unsigned MAX_B = (FV_HOLD > V_BLANK) ? FV_HOLD : V_BLANK;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW    = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {StIdle, StSetup, StLine, StHblank, StHold, StVblank} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [LW-1:0]   line_q, line_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [63:0]     pix_q;
  logic            fval_q, lval_q, dval_q;
  logic            rdy, accept, drop, sof_bad, lval_bad, last_cnt;

  assign s_axis.tready = rdy;
  assign last_cnt      = (beat_q == BW'(BEATS_PER_LINE - 1));

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    line_d  = line_q;
    cnt_d   = cnt_q + CW'(1);
    rdy     = 1'b0;
    accept  = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (en && s_axis.tvalid) begin
          // SOF beat is held on the bus until the first LINE cycle
          if (s_axis.tuser) state_d = StSetup;
          else begin
            rdy  = 1'b1;
            drop = 1'b1;
          end
        end
      end
      StSetup: begin
        if (cnt_q == CW'(FV_SETUP - 1)) begin
          state_d = StLine;
          beat_d  = '0;
          line_d  = '0;
        end
      end
      StLine: begin
        rdy   = 1'b1;
        cnt_d = '0;
        if (s_axis.tvalid) begin
          accept = 1'b1;
          beat_d = beat_q + BW'(1);
          if (s_axis.tlast || last_cnt) begin
            line_d  = line_q + LW'(1);
            state_d = (line_q == LW'(LINES_PER_FRAME - 1)) ? StHold : StHblank;
          end
        end
      end
      StHblank: begin
        if (cnt_q == CW'(H_BLANK - 1)) begin
          state_d = StLine;
          beat_d  = '0;
        end
      end
      StHold: begin
        if (cnt_q == CW'(FV_HOLD - 1)) begin
          state_d = StVblank;
          cnt_d   = '0;
        end
      end
      StVblank: begin
        if (cnt_q == CW'(V_BLANK - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign lval_bad = accept && (s_axis.tlast != last_cnt);
  assign sof_bad  = drop ||
                    (accept && s_axis.tuser && !(line_q == '0 && beat_q == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      line_q     <= '0;
      cnt_q      <= '0;
      pix_q      <= '0;
      fval_q     <= 1'b0;
      lval_q     <= 1'b0;
      dval_q     <= 1'b0;
      fstart_err <= 1'b0;
      lval_err   <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      line_q     <= line_d;
      cnt_q      <= cnt_d;
      fval_q     <= (state_q == StSetup) || (state_q == StLine) ||
                    (state_q == StHblank) || (state_q == StHold);
      lval_q     <= (state_q == StLine);
      dval_q     <= accept;
      fstart_err <= sof_bad;
      lval_err   <= lval_bad;
      if (state_q == StIdle) pix_q <= '0;
      else if (accept)       pix_q <= s_axis.tdata;
      if (state_q == StLine && !s_axis.tvalid) underrun <= 1'b1;
      else if (err_clr)                        underrun <= 1'b0;
    end
  end

  assign cmlk_data_x = {1'b0, dval_q, fval_q, lval_q, pix_q[23:0]};
  assign cmlk_data_y = {1'b0, dval_q, fval_q, lval_q, pix_q[47:24]};
  assign cmlk_data_z = {1'b0, dval_q, fval_q, lval_q, 8'h00, pix_q[63:48]};

endmodule

// File: tb/tb_axis_to_cmlk_tx.sv
// Bench for axis_to_cmlk_tx: builds a per-cycle timeline of expected outputs from frame
// descriptions and replays it against the DUT.
module tb_axis_to_cmlk_tx;
  localparam int unsigned BEATS = 4;
  localparam int unsigned LINES = 2;
  localparam int unsigned SETUP = 1;
  localparam int unsigned HB    = 2;
  localparam int unsigned HOLD  = 1;
  localparam int unsigned VB    = 3;

  logic        clk = 1'b0;
  logic        rst, en, err_clr;
  logic [27:0] x, y, z;
  logic        fse, lve, und;

  axis_to_cmlk_tx_if s_axis ();

  axis_to_cmlk_tx #(
    .BEATS_PER_LINE (BEATS),
    .LINES_PER_FRAME(LINES),
    .FV_SETUP       (SETUP),
    .H_BLANK        (HB),
    .FV_HOLD        (HOLD),
    .V_BLANK        (VB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .s_axis     (s_axis),
    .cmlk_data_x(x),
    .cmlk_data_y(y),
    .cmlk_data_z(z),
    .err_clr    (err_clr),
    .fstart_err (fse),
    .lval_err   (lve),
    .underrun   (und)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, u, l;
    logic [63:0] d;
    logic        rdy;
    logic        fv, lv, dv;
    logic [63:0] ed;
    logic        cd, fs, le, un;
  } cyc_t;

  typedef struct {
    int tlast_at, user_at, gap_after, gap_len;
  } line_t;

  cyc_t  plan[$];
  line_t lcfg[LINES];
  logic  und_model;
  int    checks   = 0;
  int    failures = 0;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic v, input logic u, input logic l, input logic [63:0] d,
                      input logic rdy, input logic fv, input logic lv, input logic dv,
                      input logic [63:0] ed, input logic cd, input logic fs, input logic le);
    cyc_t c;
    c.v = v; c.u = u; c.l = l; c.d = d; c.rdy = rdy;
    c.fv = fv; c.lv = lv; c.dv = dv; c.ed = ed; c.cd = cd; c.fs = fs; c.le = le;
    c.un = und_model;
    plan.push_back(c);
  endtask

  // Timeline of one frame from IDLE: dropped beats, SOF wait, setup, lines, blanking, idle.
  task automatic gen_frame(input int n_drop, input logic [63:0] d0);
    logic [63:0] d, last;
    logic        first, u, tl;
    int          e;
    last = '0;
    for (int i = 0; i < n_drop; i++) push(1, 0, 0, rnd64(), 1, 0, 0, 0, '0, 1, 1, 0);
    tl = (lcfg[0].tlast_at == 1);
    push(1, 1, tl, d0, 0, 0, 0, 0, '0, 1, 0, 0);
    for (int i = 0; i < int'(SETUP); i++) push(1, 1, tl, d0, 0, 1, 0, 0, '0, 0, 0, 0);
    for (int ln = 0; ln < int'(LINES); ln++) begin
      e = (lcfg[ln].tlast_at >= 1 && lcfg[ln].tlast_at < int'(BEATS)) ? lcfg[ln].tlast_at
                                                                        : int'(BEATS);
      for (int k = 1; k <= e; k++) begin
        first = (ln == 0 && k == 1);
        d     = first ? d0 : rnd64();
        u     = first || (k == lcfg[ln].user_at);
        tl    = (k == lcfg[ln].tlast_at);
        push(1, u, tl, d, 1, 1, 1, 1, d, 1, u && !first,
             (k == e) && (lcfg[ln].tlast_at != int'(BEATS)));
        last = d;
        if (k == lcfg[ln].gap_after && k < e) begin
          for (int j = 0; j < lcfg[ln].gap_len; j++) begin
            und_model = 1'b1;
            push(0, 0, 0, '0, 1, 1, 1, 0, last, 1, 0, 0);
          end
        end
      end
      if (ln < int'(LINES) - 1)
        for (int i = 0; i < int'(HB); i++) push(0, 0, 0, '0, 0, 1, 0, 0, '0, 0, 0, 0);
      else
        for (int i = 0; i < int'(HOLD); i++) push(0, 0, 0, '0, 0, 1, 0, 0, '0, 0, 0, 0);
    end
    for (int i = 0; i < int'(VB); i++) push(0, 0, 0, '0, 0, 0, 0, 0, '0, 0, 0, 0);
    push(0, 0, 0, '0, 0, 0, 0, 0, '0, 1, 0, 0);
  endtask

  task automatic step(input cyc_t c);
    s_axis.tvalid = c.v;
    s_axis.tuser  = c.u;
    s_axis.tlast  = c.l;
    s_axis.tdata  = c.d;
    #1;
    chk("tready", s_axis.tready, c.rdy);
    @(posedge clk);
    #1;
    chk("ctrl_x", x[27:24], {1'b0, c.dv, c.fv, c.lv});
    chk("ctrl_y", y[27:24], {1'b0, c.dv, c.fv, c.lv});
    chk("ctrl_z", z[27:24], {1'b0, c.dv, c.fv, c.lv});
    if (c.cd) begin
      chk("data_x", x[23:0], c.ed[23:0]);
      chk("data_y", y[23:0], c.ed[47:24]);
      chk("data_z", z[23:0], {8'h00, c.ed[63:48]});
    end
    chk("fstart_err", fse, c.fs);
    chk("lval_err", lve, c.le);
    chk("underrun", und, c.un);
  endtask

  task automatic run_plan(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) step(plan[i]);
  endtask

  task automatic run_all();
    run_plan(0, plan.size() - 1);
    plan.delete();
  endtask

  task automatic clear_und();
    s_axis.tvalid = 1'b0;
    err_clr       = 1'b1;
    @(posedge clk);
    #1;
    err_clr   = 1'b0;
    und_model = 1'b0;
    chk("underrun_clr", und, 1'b0);
  endtask

  task automatic set_lines(input int t0, input int u0, input int g0, input int gl0,
                           input int t1, input int u1, input int g1, input int gl1);
    lcfg[0].tlast_at = t0; lcfg[0].user_at = u0; lcfg[0].gap_after = g0; lcfg[0].gap_len = gl0;
    lcfg[1].tlast_at = t1; lcfg[1].user_at = u1; lcfg[1].gap_after = g1; lcfg[1].gap_len = gl1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_x"}, x, 28'h0);
    chk({tag, "_y"}, y, 28'h0);
    chk({tag, "_z"}, z, 28'h0);
    chk({tag, "_fse"}, fse, 1'b0);
    chk({tag, "_lve"}, lve, 1'b0);
    chk({tag, "_und"}, und, 1'b0);
    chk({tag, "_tready"}, s_axis.tready, 1'b0);
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; err_clr = 1'b0; und_model = 1'b0;
    s_axis.tvalid = 1'b0; s_axis.tuser = 1'b0; s_axis.tlast = 1'b0; s_axis.tdata = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    en = 1'b1;

    // Continuous beats, known first beat
    set_lines(4, 0, 0, 0, 4, 0, 0, 0);
    gen_frame(0, 64'h0706050403020100);
    run_all();

    // Stall of three clocks after beat 1, sticky underrun
    set_lines(4, 0, 1, 3, 4, 0, 0, 0);
    gen_frame(0, rnd64());
    run_all();
    chk("underrun_sticky", und, 1'b1);
    clear_und();

    // Early tlast on line 0; missing tlast and stray tuser on line 1
    set_lines(3, 0, 0, 0, 0, 2, 0, 0);
    gen_frame(0, rnd64());
    run_all();

    // Two non-SOF beats dropped in IDLE before the SOF
    set_lines(4, 0, 0, 0, 4, 0, 2, 1);
    gen_frame(2, rnd64());
    run_all();
    clear_und();

    // en dropped mid-frame: frame completes, later SOF is ignored
    set_lines(4, 0, 0, 0, 4, 0, 0, 0);
    gen_frame(0, rnd64());
    n = plan.size();
    run_plan(0, 4);
    en = 1'b0;
    run_plan(5, n - 1);
    plan.delete();
    for (int i = 0; i < 4; i++) push(1, 1, 0, rnd64(), 0, 0, 0, 0, '0, 1, 0, 0);
    run_all();
    en = 1'b1;

    // Reset in the middle of line 0
    set_lines(4, 0, 1, 2, 4, 0, 0, 0);
    gen_frame(0, rnd64());
    run_plan(0, 4);
    plan.delete();
    s_axis.tvalid = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    und_model = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      for (int ln = 0; ln < int'(LINES); ln++) begin
        lcfg[ln].tlast_at  = int'($urandom_range(0, 5));
        lcfg[ln].user_at   = int'($urandom_range(0, 4));
        lcfg[ln].gap_after = int'($urandom_range(0, 4));
        lcfg[ln].gap_len   = int'($urandom_range(1, 3));
      end
      gen_frame(int'($urandom_range(0, 2)), rnd64());
      run_all();
      clear_und();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
